// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: periodic fire attempts, alive-enemy search, id->col/row split, valid/ready issue.
// Optional FIRE_BOTTOM_EN: only the lowest alive enemy of the selected column fires.
module enemy_fire_scheduler #(
   parameter int unsigned N_ENEMY   = 65,
   parameter int unsigned COLS      = 13,
   parameter int unsigned MAX_SHOTS = 3,
   parameter int unsigned PERIOD    = 1000000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic [N_ENEMY-1:0]               enemy_vivos,
   input  logic                             fire_ready,
   input  logic                             shot_done,
   output logic                             fire_valid,
   output logic [$clog2(N_ENEMY)-1:0]       fire_id,
   output logic [5:0]                       fire_col,
   output logic [5:0]                       fire_row,
   output logic [$clog2(MAX_SHOTS+1)-1:0]   shots_active,
   output logic                             busy
);

   localparam int unsigned ID_W    = $clog2(N_ENEMY);
   localparam int unsigned SHOT_W  = $clog2(MAX_SHOTS + 1);
   localparam int unsigned TIMER_W = $clog2(PERIOD);
   localparam int unsigned SCAN_W  = $clog2(N_ENEMY + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PICK,
      S_SCAN,
      S_DROP,
      S_DIV,
      S_ISSUE
   } state_t;

   state_t              state;
   logic [TIMER_W-1:0]  timer;
   logic [15:0]         lfsr;
   logic [ID_W-1:0]     cand;
   logic [SCAN_W-1:0]   scan_cnt;
   logic [ID_W-1:0]     div_col;
   logic [5:0]          div_row;
   logic [ID_W-1:0]     pick_c;
   logic [ID_W-1:0]     next_c;
   logic                accept_c;
`ifdef FIRE_BOTTOM_EN
   logic [ID_W-1:0]     drop_idx;

   // Bottommost existing cell in the same column as c.
   function automatic logic [ID_W-1:0] bottom_of(input logic [ID_W-1:0] c);
      logic [ID_W-1:0] b;
      b = c;
      for (int unsigned r = 1; r <= N_ENEMY / COLS; r++) begin
         if (32'(c) + r * COLS < N_ENEMY) b = ID_W'(32'(c) + r * COLS);
      end
      return b;
   endfunction
`endif

   // Random start candidate folded into the enemy range, and cyclic successor.
   always_comb begin
      pick_c = lfsr[ID_W-1:0];
      if (32'(lfsr[ID_W-1:0]) >= N_ENEMY) pick_c = lfsr[ID_W-1:0] - ID_W'(N_ENEMY);
      next_c = (cand == ID_W'(N_ENEMY - 1)) ? '0 : cand + ID_W'(1);
   end

   assign accept_c = fire_valid & fire_ready;

   // Free-running LFSR, taps 16/14/13/11; only reset touches its state.
   always_ff @(posedge clk) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   // In-flight shot slots; kept across enable drops since shots still resolve.
   always_ff @(posedge clk) begin
      if (reset) begin
         shots_active <= '0;
      end else if (accept_c && !shot_done) begin
         if (shots_active < SHOT_W'(MAX_SHOTS)) shots_active <= shots_active + SHOT_W'(1);
      end else if (!accept_c && shot_done) begin
         if (shots_active != '0) shots_active <= shots_active - SHOT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         timer      <= '0;
         cand       <= '0;
         scan_cnt   <= '0;
         div_col    <= '0;
         div_row    <= '0;
         fire_valid <= 1'b0;
         fire_id    <= '0;
         fire_col   <= '0;
         fire_row   <= '0;
         busy       <= 1'b0;
`ifdef FIRE_BOTTOM_EN
         drop_idx   <= '0;
`endif
      end else if (!enable) begin
         state      <= S_IDLE;
         timer      <= '0;
         fire_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // Timer parks at its terminal value while all slots are taken.
               if (timer == TIMER_W'(PERIOD - 1)) begin
                  if (shots_active < SHOT_W'(MAX_SHOTS)) begin
                     timer <= '0;
                     state <= S_PICK;
                     busy  <= 1'b1;
                  end
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            S_PICK: begin
               cand     <= pick_c;
               scan_cnt <= '0;
               state    <= S_SCAN;
            end
            S_SCAN: begin
               if (enemy_vivos[cand]) begin
`ifdef FIRE_BOTTOM_EN
                  drop_idx <= bottom_of(cand);
                  state    <= S_DROP;
`else
                  div_col  <= cand;
                  div_row  <= '0;
                  state    <= S_DIV;
`endif
               end else if (scan_cnt == SCAN_W'(N_ENEMY - 1)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cand     <= next_c;
                  scan_cnt <= scan_cnt + SCAN_W'(1);
               end
            end
`ifdef FIRE_BOTTOM_EN
            S_DROP: begin
               // Top-row stop guards against the column emptying mid-search.
               if (enemy_vivos[drop_idx] || 32'(drop_idx) < COLS) begin
                  cand    <= drop_idx;
                  div_col <= drop_idx;
                  div_row <= '0;
                  state   <= S_DIV;
               end else begin
                  drop_idx <= drop_idx - ID_W'(COLS);
               end
            end
`endif
            S_DIV: begin
               if (32'(div_col) >= COLS) begin
                  div_col <= div_col - ID_W'(COLS);
                  div_row <= div_row + 6'd1;
               end else begin
                  fire_id    <= cand;
                  fire_col   <= 6'(div_col);
                  fire_row   <= div_row;
                  fire_valid <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (fire_ready) begin
                  fire_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state      <= S_IDLE;
               fire_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/enemy_fire_scheduler.md
Name: enemy_fire_scheduler

Overview:
Decides when enemies fire, and which one fires, for the invader game engine. A period timer triggers fire attempts, gated by a limit on concurrent enemy projectiles. A pseudo-random candidate is advanced to the next alive enemy and converted to column/row coordinates. The result is issued to the projectile spawner over a valid/ready handshake, and slots are released when shots resolve.

Parameters:
N_ENEMY, 65, number of enemies; bit i of enemy_vivos is enemy i, row-major
COLS, 13, enemies per row; id = row*COLS + col
MAX_SHOTS, 3, maximum enemy projectiles in flight (>=1)
PERIOD, 1000000, cycles between fire attempts (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  game running; low aborts scheduling
enemy_vivos  in  N_ENEMY  1 = enemy alive
fire_ready  in  1  spawner accepts the shot this cycle
shot_done  in  1  one-cycle pulse: an in-flight enemy shot ended (hit or off-screen)
fire_valid  out  1  shot request pending
fire_id  out  ID_W=$clog2(N_ENEMY)  linear index of the firing enemy
fire_col  out  6  column of the firing enemy
fire_row  out  6  row of the firing enemy
shots_active  out  $clog2(MAX_SHOTS+1)  projectiles in flight
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timer 0, LFSR = 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Shifts every cycle, including when enable is low; it is reset only by reset.
- IDLE:
  - Timer increments while enable is high.
  - At timer == PERIOD-1 with shots_active < MAX_SHOTS: timer clears and the FSM goes to PICK.
  - At timer == PERIOD-1 with slots full: timer holds at PERIOD-1 and the FSM waits until a slot frees.
- PICK (1 cycle):
  - cand = lfsr[ID_W-1:0]; if cand >= N_ENEMY, subtract N_ENEMY once.
  - scan_cnt = 0; go to SCAN.
- SCAN (1 cycle per step):
  - enemy_vivos[cand] = 1: go to DIV.
  - Otherwise cand = cand+1, wrapping N_ENEMY-1 to 0, and scan_cnt++.
  - scan_cnt reaching N_ENEMY (no enemy alive): return to IDLE with no request and no slot consumed.
- DIV (1 cycle per step): col = cand, row = 0; subtract COLS from col and increment row each cycle while col >= COLS; then go to ISSUE.
- ISSUE:
  - fire_valid = 1; fire_id/col/row are held stable until the handshake completes.
  - fire_valid & fire_ready in the same cycle: accepted, shots_active++, return to IDLE. fire_valid is low the next cycle.
  - The request is kept even if the target dies while waiting.
- Worst-case trigger-to-fire_valid latency: 2 + N_ENEMY + ceil(N_ENEMY/COLS) cycles.
- shots_active:
  - Increments on accept and decrements on shot_done.
  - Accept and shot_done in the same cycle: unchanged.
  - shot_done at 0: ignored, saturates at 0.
  - Never exceeds MAX_SHOTS.
- enable low in any state:
  - Next cycle: FSM = IDLE, fire_valid = 0, timer = 0.
  - shots_active is kept, since in-flight shots still resolve.
- Reset mid-operation: reset values on the next edge; a pending request is dropped.
- fire_id/col/row keep the last issued value while in IDLE.

Optional Feature:
FIRE_BOTTOM_EN
- Defined: a DROP state is inserted between SCAN and DIV.
  - It starts at the bottommost existing cell of cand's column and steps up by COLS per cycle until an alive enemy is found. This always terminates, since cand itself is alive.
  - The found cell becomes cand, so only the lowest alive enemy in a column fires.
  - Worst-case latency grows by ceil(N_ENEMY/COLS) cycles.
- Undefined: no DROP state; the first alive enemy found by SCAN fires.

Test Plan:
Bench uses N_ENEMY=8, COLS=4, MAX_SHOTS=2, PERIOD=4.
1. Reset asserted 3 cycles, with enable=1 and all enemies alive -> every output 0 while reset is high, and busy=0 the cycle after release.
2. Only enemy 6 alive, enable=1, fire_ready=0 -> fire_valid rises within PERIOD+12 cycles with id=6, col=2, row=1, held stable for 5 cycles. Raising fire_ready gives a single accept, shots_active=1, fire_valid=0 the next cycle.
3. enemy_vivos=0 for 10 periods -> fire_valid never asserts, shots_active stays 0, and busy pulses and returns to 0 each period.
4. fire_ready=1, all alive -> two accepts give shots_active=2, and no third fire_valid for 20 cycles. A shot_done pulse gives shots_active=1, then a new fire_valid within PERIOD+12 cycles.
5. shots_active=1, accept coinciding with shot_done -> shots_active stays 1. With shots_active=0, a shot_done pulse -> stays 0.
6. enable dropped while fire_valid=1 -> fire_valid=0 and busy=0 the next cycle, and no request within PERIOD-1 cycles after enable returns high. FIRE_BOTTOM_EN build with only enemies 1 and 5 alive -> every issue has id=5, col=1, row=1.
